vec_mem_sequencer: RTL

Per-element control sequencer for the memory-to-memory vector datapath.
- Sits directly upstream of the 16-bit operand/result registers and drives their write enables.
- Steps through a vector of length vlen, element by element:
  - reads operand A and operand B from the synchronous data memory (1-cycle read latency),
  - strobes the operand registers,
  - writes the ALU result back to the destination vector in memory.

---
 rtl/vec_pkg.sv | 17 +
 rtl/vec_idx_counter.sv | 24 ++
 rtl/vec_mem_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the memory-to-memory vector sequencers.
package vec_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int MEM_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_A = 3'd1,
        ST_FETCH_B = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/vec_idx_counter.sv
// Element index counter with clear, increment and last-element flag.
module vec_idx_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] vlen,
    output logic [LEN_W-1:0] idx,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == (vlen - 1'b1));

endmodule

// File: rtl/vec_mem_sequencer.sv
// Per-element sequencer: fetch A, fetch B, load operands, write result back.
//   state    | meaning
//   IDLE     | waiting for start, idx held at 0
//   FETCH_A  | memory address = base_a + idx
//   FETCH_B  | address = base_b + idx, A data arrives -> ld_a
//   EXEC     | B data arrives -> ld_b, address held
//   WRITE    | address = base_d + idx, mem_we; advance or finish
//   DONE     | one-cycle completion pulse
module vec_mem_sequencer
    import vec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_d,
    input  logic [LEN_W-1:0]  vlen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              ld_a,
    output logic              ld_b,
    output logic [LEN_W-1:0]  elem_idx,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] base_d_q;
    logic [LEN_W-1:0]  vlen_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] idx_addr;
    logic              idx_last;
    logic              idx_clr;
    logic              idx_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operation parameters are frozen at the accepting start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            vlen_q   <= '0;
        end else if (state == ST_IDLE && start) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            base_d_q <= base_d;
            vlen_q   <= vlen;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (vlen != '0) ? ST_FETCH_A : ST_DONE;
                end
            end
            ST_FETCH_A: state_next = ST_FETCH_B;
            ST_FETCH_B: state_next = ST_EXEC;
            ST_EXEC:    state_next = ST_WRITE;
            ST_WRITE:   state_next = idx_last ? ST_DONE : ST_FETCH_A;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) begin
            state_next = ST_IDLE;
        end
    end

    assign idx_clr = (state_next == ST_IDLE);
    assign idx_inc = (state == ST_WRITE) && !idx_last;

    vec_idx_counter #(
        .LEN_W (LEN_W)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .vlen (vlen_q),
        .idx  (idx),
        .last (idx_last)
    );

    assign idx_addr = ADDR_W'(idx);

    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        busy     = (state != ST_IDLE);
        done     = 1'b0;
        elem_idx = idx;
        case (state)
            ST_FETCH_A: mem_addr = base_a_q + idx_addr;
            ST_FETCH_B: begin
                mem_addr = base_b_q + idx_addr;
                ld_a     = 1'b1;
            end
            ST_EXEC: begin
                mem_addr = base_b_q + idx_addr;
                ld_b     = 1'b1;
            end
            ST_WRITE: begin
                mem_addr = base_d_q + idx_addr;
                mem_we   = 1'b1;
            end
            ST_DONE:    done = 1'b1;
            default:    mem_addr = '0;
        endcase
    end

endmodule
